btn_mode_router: RTL and testbench

Parametrised front-end for the board push-buttons. It takes N_BTN raw button inputs and, per channel, synchronises and debounces them, then detects press edges, long-press and auto-repeat. Resulting one-cycle event pulses are routed to one of N_MODE output banks selected by a mode input. It feeds the stopwatch/clock controllers and supersedes the fixed 3-button, 2-mode router and its separate debouncers.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_chan.sv | 125 ++++++++++++
 rtl/btn_mode_router.sv | 80 ++++++++
 tb/tb_btn_mode_router.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button front-end: FSM encoding,
// compile-time log2 and the flat bank/button index used on the routed outputs.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } btn_state_t;

  function automatic int btn_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

`define BTN_IDX(m, b) ((m) * N_BTN + (b))

// File: rtl/btn_chan.sv
// One button channel: 2-FF synchroniser, tick-based debouncer, hold/repeat
// FSM and the bank latched at press time.
module btn_chan
  import btn_pkg::*;
#(
  parameter int DB_TICKS     = 5,
  parameter int LONG_TICKS   = 800,
  parameter int REPEAT_TICKS = 200,
  parameter int MW           = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_tick,
  input  logic [MW-1:0] i_mode,
  input  logic          i_btn,
  output logic          o_level,
  output logic          o_press,
  output logic          o_long,
  output logic          o_busy,
  output logic [MW-1:0] o_bank
);

  localparam int DW = btn_clog2(DB_TICKS) + 1;
  localparam int HW = btn_clog2(LONG_TICKS) + 1;
  localparam int RW = btn_clog2(REPEAT_TICKS) + 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_tick_p1;
  logic          r_level;
  logic [DW-1:0] r_db_cnt;
  logic [HW-1:0] r_hold;
  logic [RW-1:0] r_rep;
  logic          r_press;
  logic          r_long;
  logic [MW-1:0] r_bank;
  btn_state_t    r_state;

  // Stage p0: synchronise and debounce on the sample tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_tick_p1 <= 1'b0;
      r_level   <= 1'b0;
      r_db_cnt  <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_tick_p1 <= i_tick;
      if (i_tick) begin
        if (r_sync2 != r_level) begin
          if (r_db_cnt >= DW'(DB_TICKS - 1)) begin
            r_level  <= ~r_level;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end else begin
          r_db_cnt <= '0;
        end
      end
    end
  end

  // Stage p1: hold FSM runs one cycle behind the debouncer, so it counts the
  // delayed tick to keep long/repeat spacing an exact multiple of TICK_DIV
  // from the press pulse. Release wins over a coincident repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_rep   <= '0;
      r_press <= 1'b0;
      r_long  <= 1'b0;
      r_bank  <= '0;
    end else begin
      r_press <= 1'b0;
      r_long  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_level) begin
            r_state <= ST_HELD;
            r_press <= 1'b1;
            r_bank  <= i_mode;
            r_hold  <= '0;
          end
        end
        ST_HELD: begin
          if (!r_level) begin
            r_state <= ST_IDLE;
          end else if (r_tick_p1) begin
            if (r_hold >= HW'(LONG_TICKS - 1)) begin
              r_long  <= 1'b1;
              r_state <= ST_LONG;
              r_rep   <= '0;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
        end
        ST_LONG: begin
          if (!r_level) begin
            r_state <= ST_IDLE;
          end else if ((REPEAT_TICKS > 0) && r_tick_p1) begin
            if (r_rep >= RW'(REPEAT_TICKS - 1)) begin
              r_press <= 1'b1;
              r_rep   <= '0;
            end else begin
              r_rep <= r_rep + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;
  assign o_long  = r_long;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_bank  = r_bank;

endmodule

// File: rtl/btn_mode_router.sv
// Push-button front-end: shared sample tick, per-channel debounce/hold logic,
// and routing of each hold's pulses to the bank latched when it was pressed.
module btn_mode_router
  import btn_pkg::*;
#(
  parameter int N_BTN        = 3,
  parameter int N_MODE       = 2,
  parameter int TICK_DIV     = 100000,
  parameter int DB_TICKS     = 5,
  parameter int LONG_TICKS   = 800,
  parameter int REPEAT_TICKS = 200,
  localparam int MW = (btn_clog2(N_MODE) > 1) ? btn_clog2(N_MODE) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MW-1:0]             mode,
  input  logic [N_BTN-1:0]          btn_raw,
  output logic [N_BTN-1:0]          o_level,
  output logic [N_MODE*N_BTN-1:0]   o_press,
  output logic [N_MODE*N_BTN-1:0]   o_long,
  output logic [N_BTN-1:0]          o_busy
);

  localparam int TW = btn_clog2(TICK_DIV) + 1;

  logic [TW-1:0]    r_tick_cnt;
  logic             r_tick;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_long;
  logic [MW-1:0]    w_bank [N_BTN];

  // Stage p0: free-running tick, high for the cycle in which the count is 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else if (r_tick_cnt == TW'(TICK_DIV - 1)) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
      r_tick     <= 1'b0;
    end
  end

  for (genvar b = 0; b < N_BTN; b++) begin : g_chan
    btn_chan #(
      .DB_TICKS    (DB_TICKS),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .MW          (MW)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .i_tick (r_tick),
      .i_mode (mode),
      .i_btn  (btn_raw[b]),
      .o_level(o_level[b]),
      .o_press(w_press[b]),
      .o_long (w_long[b]),
      .o_busy (o_busy[b]),
      .o_bank (w_bank[b])
    );
  end

  // A bank index outside 0..N_MODE-1 matches no bank, so that hold is dropped
  always_comb begin
    o_press = '0;
    o_long  = '0;
    for (int m = 0; m < N_MODE; m++) begin
      for (int b = 0; b < N_BTN; b++) begin
        if (int'(w_bank[b]) == m) begin
          o_press[`BTN_IDX(m, b)] = w_press[b];
          o_long[`BTN_IDX(m, b)]  = w_long[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_mode_router.sv
// Scoreboard bench for btn_mode_router: stimulus queues expected pulses with
// cycle windows, a negedge monitor pops and checks every pulse it sees.
module tb_btn_mode_router;

  localparam int N_BTN        = 3;
  localparam int N_MODE       = 2;
  localparam int TICK_DIV     = 4;
  localparam int DB_TICKS     = 3;
  localparam int LONG_TICKS   = 10;
  localparam int REPEAT_TICKS = 5;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [0:0]              mode = 1'b0;
  logic [N_BTN-1:0]        btn_raw = '0;
  logic [N_BTN-1:0]        o_level;
  logic [N_MODE*N_BTN-1:0] o_press;
  logic [N_MODE*N_BTN-1:0] o_long;
  logic [N_BTN-1:0]        o_busy;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int last_cyc = 0;
  int R;
  logic p;

  typedef struct {
    int tag;
    int kind;
    int bitn;
    bit rel;
    int lo;
    int hi;
  } exp_t;
  exp_t q[$];

  btn_mode_router #(
    .N_BTN(N_BTN), .N_MODE(N_MODE), .TICK_DIV(TICK_DIV),
    .DB_TICKS(DB_TICKS), .LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .btn_raw(btn_raw),
    .o_level(o_level), .o_press(o_press), .o_long(o_long), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int tag, input int kind, input int bitn,
                      input bit rel, input int lo, input int hi);
    exp_t e;
    e.tag = tag; e.kind = kind; e.bitn = bitn; e.rel = rel; e.lo = lo; e.hi = hi;
    q.push_back(e);
  endtask

  task automatic mon_pulse(input int k, input int b);
    exp_t e;
    int lo, hi;
    n_checks++;
    if (q.size() == 0) begin
      $display("FAIL unexpected_pulse: got kind=%0d bit=%0d at cyc %0d, required no pulse", k, b, cyc);
    end else begin
      e  = q.pop_front();
      lo = e.rel ? last_cyc + e.lo : e.lo;
      hi = e.rel ? last_cyc + e.hi : e.hi;
      if (e.kind == k && e.bitn == b && cyc >= lo && cyc <= hi) n_pass++;
      else $display("FAIL pulse_t%0d: got kind=%0d bit=%0d cyc=%0d, required kind=%0d bit=%0d cyc %0d..%0d",
                    e.tag, k, b, cyc, e.kind, e.bitn, lo, hi);
    end
    last_cyc = cyc;
  endtask

  // kind 0 = press, kind 1 = long
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int b = 0; b < N_MODE * N_BTN; b++) begin
          p = (k == 0) ? o_press[b] : o_long[b];
          if (p) mon_pulse(k, b);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic drain(input string name);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL %s: %0d expected pulses never seen, required 0", name, q.size());
    q.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    wait_cyc(3);
    chk("rst_level", 32'(o_level), 0);
    chk("rst_busy",  32'(o_busy), 0);
    chk("rst_press", 32'(o_press), 0);
    chk("rst_long",  32'(o_long), 0);
    rst = 1'b0;
    wait_cyc(5);

    // 1: clean press, bank 0, released before long
    mode = 1'b0;
    R = cyc;
    btn_raw[0] = 1'b1;
    push(1, 0, 0, 1'b0, R + 11, R + 15);
    wait_cyc(19);
    chk("t1_level_held", 32'(o_level[0]), 1);
    chk("t1_busy_held",  32'(o_busy[0]), 1);
    wait_cyc(1);
    btn_raw[0] = 1'b0;
    wait_cyc(30);
    chk("t1_level_rel", 32'(o_level[0]), 0);
    chk("t1_busy_rel",  32'(o_busy[0]), 0);
    drain("t1_missing");

    // 2: bounce shorter than the debounce window
    for (int i = 0; i < 8; i++) begin
      btn_raw[1] = ~btn_raw[1];
      wait_cyc(3);
      chk("t2_level_bounce", 32'(o_level[1]), 0);
    end
    btn_raw[1] = 1'b0;
    wait_cyc(20);
    chk("t2_busy", 32'(o_busy[1]), 0);
    drain("t2_missing");

    // 3: long press and auto-repeat in bank 1
    mode = 1'b1;
    R = cyc;
    btn_raw[2] = 1'b1;
    push(3, 0, 5, 1'b0, R + 11, R + 15);
    push(3, 1, 5, 1'b1, 40, 40);
    push(3, 0, 5, 1'b1, 20, 20);
    wait_cyc(79);
    chk("t3_level_held", 32'(o_level[2]), 1);
    wait_cyc(1);
    btn_raw[2] = 1'b0;
    wait_cyc(30);
    chk("t3_busy_rel", 32'(o_busy[2]), 0);
    drain("t3_missing");

    // 4: mode change mid-hold keeps the original bank
    mode = 1'b0;
    R = cyc;
    btn_raw[0] = 1'b1;
    push(4, 0, 0, 1'b0, R + 11, R + 15);
    push(4, 1, 0, 1'b1, 40, 40);
    wait_cyc(20);
    mode = 1'b1;
    wait_cyc(38);
    btn_raw[0] = 1'b0;
    wait_cyc(30);
    drain("t4_missing");
    R = cyc;
    btn_raw[0] = 1'b1;
    push(4, 0, 3, 1'b0, R + 11, R + 15);
    wait_cyc(20);
    btn_raw[0] = 1'b0;
    wait_cyc(30);
    drain("t4b_missing");

    // 5: simultaneous presses on two channels
    mode = 1'b0;
    R = cyc;
    btn_raw = 3'b101;
    push(5, 0, 0, 1'b0, R + 11, R + 15);
    push(5, 0, 2, 1'b1, 0, 0);
    wait_cyc(20);
    chk("t5_level", 32'(o_level), 32'h5);
    btn_raw = 3'b000;
    wait_cyc(30);
    drain("t5_missing");

    // 6: asynchronous reset during LONG, button still held
    R = cyc;
    btn_raw[0] = 1'b1;
    push(6, 0, 0, 1'b0, R + 11, R + 15);
    push(6, 1, 0, 1'b1, 40, 40);
    wait_cyc(60);
    chk("t6_busy_long", 32'(o_busy[0]), 1);
    drain("t6_missing_pre");
    rst = 1'b1;
    #1;
    chk("t6_rst_level", 32'(o_level), 0);
    chk("t6_rst_busy",  32'(o_busy), 0);
    chk("t6_rst_press", 32'(o_press), 0);
    chk("t6_rst_long",  32'(o_long), 0);
    wait_cyc(3);
    rst = 1'b0;
    R = cyc;
    push(6, 0, 0, 1'b0, R + 11, R + 15);
    push(6, 1, 0, 1'b1, 40, 40);
    wait_cyc(58);
    btn_raw[0] = 1'b0;
    wait_cyc(30);
    chk("t6_busy_end", 32'(o_busy), 0);
    drain("t6_missing_post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
